// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan multiplexer.
package seg7_pkg;

   localparam int N_DIGITS_DEF = 8;
   localparam int CLK_DIV_DEF = 50000;

   // All anodes high: every digit of the common-anode display is dark.
   localparam logic [7:0] ANODES_OFF = 8'hFF;

   typedef logic [2:0] digit_idx_t;
   typedef logic [3:0] nibble_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler that produces a one-cycle tick every CLK_DIV clocks.
// The tick marks the edge on which the scanner moves to the next digit.
module scan_tick_gen
   import seg7_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] count_q;
   logic [PW-1:0] count_d;

   // Tick on the terminal count and fold back to zero on the same edge,
   // so each digit dwells exactly CLK_DIV cycles.
   always_comb begin
      tick_o = (count_q == LAST);
      count_d = tick_o ? '0 : count_q + 1'b1;
   end

   // Counter register; synchronous reset restarts the dwell period.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display.
// Host writes land in a pending buffer and are committed to the displayed
// value only when the scan wraps from the last digit back to digit 0, so a
// frame never shows a mix of old and new nibbles. BCD_4bits is meant to be
// fed to a BCD_to_sevenSeg decoder instantiated one level up.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int N_DIGITS = N_DIGITS_DEF,
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] value_in,
   input  logic                  load,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  blank_lz,
   output logic [3:0]            BCD_4bits,
   output logic [N_DIGITS-1:0]   anodes,
   output logic                  dp_out,
   output logic [IW-1:0]         digit_idx,
   output logic                  frame_done
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);
   localparam logic [N_DIGITS-1:0] DARK = ANODES_OFF[N_DIGITS-1:0];

   logic tick;

   logic [4*N_DIGITS-1:0] pendVal_q, pendVal_d;
   logic [N_DIGITS-1:0]   pendDp_q, pendDp_d;
   logic [4*N_DIGITS-1:0] dispVal_q, dispVal_d;
   logic [N_DIGITS-1:0]   dispDp_q, dispDp_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [N_DIGITS-1:0]   anodes_q, anodes_d;
   nibble_t               bcd_q, bcd_d;
   logic                  dpOut_q, dpOut_d;
   logic                  frameDone_q, frameDone_d;

   logic    frameWrap;
   logic    leadZero;
   logic    blankDigit;
   nibble_t curNibble;

   scan_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick_o(tick)
   );

   // Next-state logic: buffer host writes, commit at frame wrap, advance
   // the scan index on each tick and precompute the registered digit drive
   // from the value that will be on display after this edge.
   always_comb begin
      pendVal_d = pendVal_q;
      pendDp_d = pendDp_q;
      dispVal_d = dispVal_q;
      dispDp_d = dispDp_q;
      idx_d = idx_q;
      anodes_d = anodes_q;
      bcd_d = bcd_q;
      dpOut_d = dpOut_q;
      frameWrap = tick && (idx_q == LAST_IDX);
      frameDone_d = frameWrap;
      leadZero = 1'b1;
      blankDigit = 1'b0;
      curNibble = 4'h0;

      if (load) begin
         pendVal_d = value_in;
         pendDp_d = dp_in;
      end

      // A load coinciding with the wrap goes straight to the display so the
      // host never loses a whole frame to the pending register.
      if (frameWrap) begin
         dispVal_d = load ? value_in : pendVal_q;
         dispDp_d = load ? dp_in : pendDp_q;
      end

      if (tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

         for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_d) && dispVal_d[4*j +: 4] != 4'h0) begin
               leadZero = 1'b0;
            end
            if (j == int'(idx_d)) begin
               curNibble = dispVal_d[4*j +: 4];
            end
         end

         blankDigit = blank_lz && (idx_d != '0) && leadZero && !dispDp_d[idx_d];

         if (blankDigit) begin
            anodes_d = DARK;
            bcd_d = 4'h0;
            dpOut_d = 1'b1;
         end else begin
            anodes_d = ~(ONE_HOT0 << idx_d);
            bcd_d = curNibble;
            dpOut_d = ~dispDp_d[idx_d];
         end
      end
   end

   // State and output registers; reset darkens the display, parks the index
   // on the last digit so the first tick lands on digit 0, and discards any
   // pending host value.
   always_ff @(posedge clk) begin
      if (reset) begin
         pendVal_q <= '0;
         pendDp_q <= '0;
         dispVal_q <= '0;
         dispDp_q <= '0;
         idx_q <= LAST_IDX;
         anodes_q <= DARK;
         bcd_q <= 4'h0;
         dpOut_q <= 1'b1;
         frameDone_q <= 1'b0;
      end else begin
         pendVal_q <= pendVal_d;
         pendDp_q <= pendDp_d;
         dispVal_q <= dispVal_d;
         dispDp_q <= dispDp_d;
         idx_q <= idx_d;
         anodes_q <= anodes_d;
         bcd_q <= bcd_d;
         dpOut_q <= dpOut_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign BCD_4bits = bcd_q;
   assign anodes = anodes_q;
   assign dp_out = dpOut_q;
   assign digit_idx = idx_q;
   assign frame_done = frameDone_q;

endmodule
